// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared constants, requester ids and helpers for the sprite ROM arbiter.
package sprite_arb_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int SPRITE_ADDR_W = 10;
  localparam int PAL_IDX_W     = 3;
  localparam int DEF_ROM_LAT   = 1;

  typedef enum logic [1:0] {
    REQ_LINK  = 2'd0,
    REQ_ENEMY = 2'd1,
    REQ_ITEM  = 2'd2,
    REQ_HUD   = 2'd3
  } req_id_e;

  // Explicit wrap so non-power-of-two requester counts never reach NUM_REQ.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v == n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester/ROM bundle between the sprite address generators and the shared ROM.
interface sprite_rom_arbiter_if
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = SPRITE_ADDR_W,
  parameter int DATA_W  = PAL_IDX_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;

  modport slave (
    input  req_valid, req_addr, rom_q,
    output req_ready, rom_address, rsp_valid, rsp_data, busy
  );

  modport master (
    output req_valid, req_addr, rom_q,
    input  req_ready, rom_address, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational rotate-priority find-first: scans from i_ptr upward with wrap.
module rr_pick
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = $clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_any
);
  logic [PTR_W-1:0] w_scan;

  always_comb begin
    // NOTE: every output gets a default first so no path through the loop infers a latch.
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_scan = i_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_any && i_req[w_scan]) begin
        o_any         = 1'b1;
        o_gnt[w_scan] = 1'b1;
        o_idx         = w_scan;
      end
      w_scan = PTR_W'(wrap_inc(32'(w_scan), NUM_REQ));
    end
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM; returns each word tagged to its requester.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = SPRITE_ADDR_W,
  parameter int DATA_W  = PAL_IDX_W,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input logic                 vga_clk,
  input logic                 reset,
  sprite_rom_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   r_rr_ptr;
  logic [ADDR_W-1:0]  r_last_addr;
  logic [NUM_REQ-1:0] r_tag [ROM_LAT];

  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_gnt;
  logic [PTR_W-1:0]   w_idx;
  logic               w_any;
  logic [ADDR_W-1:0]  w_grant_addr;
  logic               w_inflight;

  // Grants are suppressed while reset is held so nothing is accepted then lost.
  assign w_req = reset ? '0 : bus.req_valid;

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_grant_addr    = bus.req_addr[w_idx*ADDR_W +: ADDR_W];
  assign bus.req_ready   = w_gnt;
  assign bus.rom_address = w_any ? w_grant_addr : r_last_addr;
  assign bus.rsp_valid   = r_tag[ROM_LAT-1];
  assign bus.rsp_data    = bus.rom_q;

  always_comb begin
    w_inflight = 1'b0;
    for (int s = 0; s < ROM_LAT; s++) w_inflight = w_inflight | (|r_tag[s]);
  end

  assign bus.busy = (|bus.req_valid) | w_inflight;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_last_addr <= '0;
      // NOTE: the tag stages are reset on purpose; that is what discards reads in flight.
      for (int s = 0; s < ROM_LAT; s++) r_tag[s] <= '0;
    end else begin
      if (w_any) begin
        r_rr_ptr    <= PTR_W'(wrap_inc(32'(w_idx), NUM_REQ));
        r_last_addr <= w_grant_addr;
      end
      r_tag[0] <= w_gnt;
      for (int s = 1; s < ROM_LAT; s++) r_tag[s] <= r_tag[s-1];
    end
  end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench: three arbiter instances (4 req/lat 1, 4 req/lat 3, 3 req/lat 1).
module tb_sprite_rom_arbiter;
  import sprite_arb_pkg::*;

  logic vga_clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 vga_clk = ~vga_clk;

  sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(3)) bus_a ();
  sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(3)) bus_b ();
  sprite_rom_arbiter_if #(.NUM_REQ(3), .ADDR_W(10), .DATA_W(3)) bus_c ();

  sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(3), .ROM_LAT(1)) dut_a (
    .vga_clk (vga_clk), .reset (reset), .bus (bus_a.slave));
  sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(3), .ROM_LAT(3)) dut_b (
    .vga_clk (vga_clk), .reset (reset), .bus (bus_b.slave));
  sprite_rom_arbiter #(.NUM_REQ(3), .ADDR_W(10), .DATA_W(3), .ROM_LAT(1)) dut_c (
    .vga_clk (vga_clk), .reset (reset), .bus (bus_c.slave));

  // ROM models: word = addr[2:0] + 1, with the latency of each instance.
  logic [2:0] rom_b_pipe [3];
  always @(posedge vga_clk) bus_a.rom_q <= bus_a.rom_address[2:0] + 3'd1;
  always @(posedge vga_clk) bus_c.rom_q <= bus_c.rom_address[2:0] + 3'd1;
  always @(posedge vga_clk) begin
    rom_b_pipe[0] <= bus_b.rom_address[2:0] + 3'd1;
    rom_b_pipe[1] <= rom_b_pipe[0];
    rom_b_pipe[2] <= rom_b_pipe[1];
  end
  assign bus_b.rom_q = rom_b_pipe[2];

  logic [9:0] addr_a [4] = '{10'h011, 10'h022, 10'h033, 10'h044};
  logic [9:0] addr_b [4] = '{10'h155, 10'h2AA, 10'h3FF, 10'h001};
  logic [9:0] addr_c [3] = '{10'h007, 10'h00E, 10'h015};

  function automatic logic [2:0] rom_word(input logic [9:0] a);
    return a[2:0] + 3'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge vga_clk);
  endtask

  initial begin
    logic [9:0] prev_addr;
    reset = 1'b1;
    bus_a.req_valid = 4'hF;
    bus_b.req_valid = '0;
    bus_c.req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      bus_a.req_addr[i*10 +: 10] = addr_a[i];
      bus_b.req_addr[i*10 +: 10] = addr_b[i];
    end
    for (int i = 0; i < 3; i++) bus_c.req_addr[i*10 +: 10] = addr_c[i];

    // Reset held two cycles with all requesters asking.
    for (int i = 0; i < 2; i++) begin
      sample();
      check("rst_ready", 32'(bus_a.req_ready), 0);
      if (i == 1) begin
        check("rst_rsp_valid", 32'(bus_a.rsp_valid), 0);
        check("rst_addr", 32'(bus_a.rom_address), 0);
      end
      step();
    end
    reset = 1'b0;

    // Full rotation 0,1,2,3,0 with responses one cycle behind.
    for (int k = 0; k < 5; k++) begin
      sample();
      check("rot_ready", 32'(bus_a.req_ready), 1 << (k % 4));
      check("rot_addr", 32'(bus_a.rom_address), 32'(addr_a[k % 4]));
      if (k == 0) check("rot_rsp_first", 32'(bus_a.rsp_valid), 0);
      else begin
        check("rot_rsp_valid", 32'(bus_a.rsp_valid), 1 << ((k - 1) % 4));
        check("rot_rsp_data", 32'(bus_a.rsp_data), 32'(rom_word(addr_a[(k - 1) % 4])));
      end
      step();
    end
    bus_a.req_valid = '0;
    sample();
    check("tail_ready", 32'(bus_a.req_ready), 0);
    check("tail_rsp_valid", 32'(bus_a.rsp_valid), 32'h1);
    check("tail_rsp_data", 32'(bus_a.rsp_data), 32'(rom_word(addr_a[0])));
    check("tail_busy", 32'(bus_a.busy), 1);
    step();
    sample();
    check("idle_rsp_valid", 32'(bus_a.rsp_valid), 0);
    check("idle_busy", 32'(bus_a.busy), 0);
    check("idle_hold_addr", 32'(bus_a.rom_address), 32'(addr_a[0]));

    // Single requester (item); first grant moves rr_ptr to 3.
    step();
    bus_a.req_valid = 4'b0100;
    bus_a.req_addr[20 +: 10] = 10'h100;
    prev_addr = 10'h100;
    sample();
    check("single_prime", 32'(bus_a.req_ready), 32'(1 << REQ_ITEM));
    for (int j = 0; j < 5; j++) begin
      step();
      bus_a.req_addr[20 +: 10] = 10'h101 + 10'(j);
      sample();
      check("single_ready", 32'(bus_a.req_ready), 32'h4);
      check("single_addr", 32'(bus_a.rom_address), 32'h101 + j);
      check("single_rsp_valid", 32'(bus_a.rsp_valid), 32'h4);
      check("single_rsp_data", 32'(bus_a.rsp_data), 32'(rom_word(prev_addr)));
      prev_addr = 10'h101 + 10'(j);
    end

    // Fairness: requester 1 pulsed while rr_ptr=1 beats the steady requester 0.
    step();
    bus_a.req_valid = 4'b0001;
    sample();
    check("fair_0_first", 32'(bus_a.req_ready), 32'h1);
    step();
    bus_a.req_valid = 4'b0011;
    sample();
    check("fair_1_wins", 32'(bus_a.req_ready), 32'h2);
    check("fair_1_addr", 32'(bus_a.rom_address), 32'(addr_a[1]));
    check("fair_rsp0", 32'(bus_a.rsp_valid), 32'h1);
    step();
    bus_a.req_valid = 4'b0001;
    sample();
    check("fair_0_next", 32'(bus_a.req_ready), 32'h1);
    check("fair_rsp1", 32'(bus_a.rsp_valid), 32'h2);
    check("fair_rsp1_data", 32'(bus_a.rsp_data), 32'(rom_word(addr_a[1])));
    step();
    bus_a.req_valid = '0;

    // Latency 3: three reads in flight, then a one-cycle reset.
    bus_b.req_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("b_ready", 32'(bus_b.req_ready), 1 << k);
      check("b_no_early_rsp", 32'(bus_b.rsp_valid), 0);
      check("b_busy", 32'(bus_b.busy), 1);
      step();
    end
    bus_b.req_valid = '0;
    reset = 1'b1;
    sample();
    check("b_rsp0_lat3", 32'(bus_b.rsp_valid), 32'h1);
    check("b_rsp0_data", 32'(bus_b.rsp_data), 32'(rom_word(addr_b[0])));
    check("b_rst_ready", 32'(bus_b.req_ready), 0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("b_flushed_rsp", 32'(bus_b.rsp_valid), 0);
      check("b_flushed_busy", 32'(bus_b.busy), 0);
      check("b_flushed_addr", 32'(bus_b.rom_address), 0);
      step();
    end

    // Three requesters: rotation 0,1,2,0,... with an explicit pointer wrap.
    bus_c.req_valid = 3'b111;
    for (int k = 0; k < 7; k++) begin
      sample();
      check("c_ready", 32'(bus_c.req_ready), 1 << (k % 3));
      check("c_addr", 32'(bus_c.rom_address), 32'(addr_c[k % 3]));
      check("c_ptr", 32'(dut_c.r_rr_ptr), k % 3);
      if (k > 0) begin
        check("c_rsp_valid", 32'(bus_c.rsp_valid), 1 << ((k - 1) % 3));
        check("c_rsp_data", 32'(bus_c.rsp_data), 32'(rom_word(addr_c[(k - 1) % 3])));
      end
      step();
    end
    bus_c.req_valid = '0;
    sample();
    check("c_last_rsp", 32'(bus_c.rsp_valid), 32'h1);
    check("c_ptr_after", 32'(dut_c.r_rr_ptr), 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
